register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 19 +
 rtl/rf_read_port.sv | 45 ++++
 rtl/register_file.sv | 58 +++++
 tb/tb_register_file.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, types and helpers for the MIPS general-purpose register file.
// Purely declarative: no logic, no latency.
// No flow control lives here.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Register $zero is architecturally constant; every path that touches an
  // address asks this one question.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == '0);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: address decode, $zero force, optional forwarding.
// Latency: zero cycles, purely combinational from address, array and write bus.
// Backpressure: none; the port always answers.
// Forwarding mux is present only when REGFILE_BYPASS_EN is defined.
module rf_read_port
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  reg_addr_t                       addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                            fwd_vld,
  input  reg_addr_t                       fwd_addr,
  input  reg_data_t                       fwd_dat,
`endif
  output reg_data_t                       data
);

  reg_data_t array_dat;

  // Plain array lookup; entry 0 is masked so pre-reset contents never leak.
  always_comb begin
    array_dat = regs[addr];
    if (is_zero_reg(addr)) begin
      array_dat = '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write-back value so decode sees it this cycle.
  // fwd_vld is already qualified against reset and $zero by the top level,
  // but the zero check is repeated so $zero can never be overridden.
  always_comb begin
    data = array_dat;
    if (fwd_vld && (fwd_addr == addr) && !is_zero_reg(addr)) begin
      data = fwd_dat;
    end
  end
`else
  // Without forwarding the port shows the pre-edge array contents.
  always_comb begin
    data = array_dat;
  end
`endif

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit MIPS register file: 2 async read ports, 1 sync write port, $zero hardwired.
// Latency: reads 0 cycles; writes visible the cycle after the edge (same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; Write is a bare strobe already gated by the conditional-move logic.
module register_file
  import regfile_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Write,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr_commit;

  // A write lands only when strobed, outside reset, and not aimed at $zero.
  // A suppressed MOVZ/MOVN arrives here as Write=0 and therefore touches nothing.
  always_comb begin
    wr_commit = Write && !Reset && !is_zero_reg(WriteRegister);
  end

  // Storage update: reset clears every entry and wins over a coincident write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      regs <= '0;
    end else if (wr_commit) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  rf_read_port u_port1 (
    .regs     (regs),
    .addr     (ReadRegister1),
`ifdef REGFILE_BYPASS_EN
    .fwd_vld  (wr_commit),
    .fwd_addr (WriteRegister),
    .fwd_dat  (WriteData),
`endif
    .data     (ReadData1)
  );

  rf_read_port u_port2 (
    .regs     (regs),
    .addr     (ReadRegister2),
`ifdef REGFILE_BYPASS_EN
    .fwd_vld  (wr_commit),
    .fwd_addr (WriteRegister),
    .fwd_dat  (WriteData),
`endif
    .data     (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs change 1 ns after the rising edge and outputs are sampled 1 ns later.
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_register_file;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Write;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int tests_run;
  int tests_failed;

  register_file dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .Write         (Write),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance through one rising edge and let inputs/outputs settle after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] dat);
    Write = 1'b1;
    WriteRegister = addr;
    WriteData = dat;
    tick();
    Write = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] pre [32];
    for (int i = 1; i < 32; i++) begin
      pre[i] = $urandom | 32'h1;
      write_reg(i[4:0], pre[i]);
    end
    // Preload sanity: two entries must hold what was written.
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd31;
    #1;
    tests_run++;
    if (ReadData1 !== pre[3]) begin
      tests_failed++;
      $display("FAIL preload_r3: got %08h expected %08h", ReadData1, pre[3]);
    end
    tests_run++;
    if (ReadData2 !== pre[31]) begin
      tests_failed++;
      $display("FAIL preload_r31: got %08h expected %08h", ReadData2, pre[31]);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = i[4:0];
      ReadRegister2 = 5'(31 - i);
      #1;
      tests_run++;
      if (ReadData1 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_port1[%0d]: got %08h expected 00000000", i, ReadData1);
      end
      tests_run++;
      if (ReadData2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_port2[%0d]: got %08h expected 00000000", 31 - i, ReadData2);
      end
    end
  endtask

  task automatic test_basic_write();
    write_reg(5'd5, 32'hDEADBEEF);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd6;
    #1;
    tests_run++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL basic_r5: got %08h expected DEADBEEF", ReadData1);
    end
    tests_run++;
    if (ReadData2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL basic_r6: got %08h expected 00000000", ReadData2);
    end
  endtask

  task automatic test_suppressed_move();
    Write = 1'b0;
    WriteRegister = 5'd5;
    WriteData = 32'h12345678;
    tick();
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd5;
    #1;
    tests_run++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL suppressed_p1: got %08h expected DEADBEEF", ReadData1);
    end
    tests_run++;
    if (ReadData2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL suppressed_p2: got %08h expected DEADBEEF", ReadData2);
    end
  endtask

  task automatic test_reg_zero();
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd5;
    Write = 1'b1;
    WriteRegister = 5'd0;
    WriteData = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL r0_before: got %08h expected 00000000", ReadData1);
    end
    tick();
    Write = 1'b0;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL r0_after: got %08h expected 00000000", ReadData1);
    end
    // No side effect on other entries.
    tests_run++;
    if (ReadData2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL r0_side_effect: got %08h expected DEADBEEF", ReadData2);
    end
  endtask

  task automatic test_reset_collision();
    write_reg(5'd9, 32'h00000099);
    Reset = 1'b1;
    Write = 1'b1;
    WriteRegister = 5'd9;
    WriteData = 32'hA5A5A5A5;
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd5;
    #1;
    // Reset disqualifies forwarding too, so the old value shows before the edge.
    tests_run++;
    if (ReadData1 !== 32'h00000099) begin
      tests_failed++;
      $display("FAIL collision_before: got %08h expected 00000099", ReadData1);
    end
    tick();
    Reset = 1'b0;
    Write = 1'b0;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL collision_r9: got %08h expected 00000000", ReadData1);
    end
    tests_run++;
    if (ReadData2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL collision_r5: got %08h expected 00000000", ReadData2);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_before;
    write_reg(5'd7, 32'h00000777);
    Write = 1'b1;
    WriteRegister = 5'd7;
    WriteData = 32'h0BADF00D;
    ReadRegister1 = 5'd8;
    ReadRegister2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_before = 32'h0BADF00D;
`else
    exp_before = 32'h00000777;
`endif
    #1;
    tests_run++;
    if (ReadData2 !== exp_before) begin
      tests_failed++;
      $display("FAIL bypass_before: got %08h expected %08h", ReadData2, exp_before);
    end
    tests_run++;
    if (ReadData1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_other_port: got %08h expected 00000000", ReadData1);
    end
    tick();
    Write = 1'b0;
    #1;
    tests_run++;
    if (ReadData2 !== 32'h0BADF00D) begin
      tests_failed++;
      $display("FAIL bypass_after: got %08h expected 0BADF00D", ReadData2);
    end
  endtask

  task automatic test_back_to_back();
    write_reg(5'd1, 32'h11111111);
    write_reg(5'd2, 32'h22222222);
    write_reg(5'd3, 32'h33333333);
    write_reg(5'd1, 32'h44444444);
    ReadRegister1 = 5'd1;
    ReadRegister2 = 5'd3;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h44444444) begin
      tests_failed++;
      $display("FAIL b2b_r1: got %08h expected 44444444", ReadData1);
    end
    tests_run++;
    if (ReadData2 !== 32'h33333333) begin
      tests_failed++;
      $display("FAIL b2b_r3: got %08h expected 33333333", ReadData2);
    end
    ReadRegister1 = 5'd2;
    ReadRegister2 = 5'd2;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h22222222 || ReadData2 !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL same_addr_r2: got %08h/%08h expected 22222222", ReadData1, ReadData2);
    end
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    write_reg(5'd31, 32'h80000001);
    tests_run++;
    if (ReadData1 !== 32'h80000001 || ReadData2 !== 32'h80000001) begin
      tests_failed++;
      $display("FAIL top_entry_r31: got %08h/%08h expected 80000001", ReadData1, ReadData2);
    end
  endtask

  task automatic test_mid_reset();
    write_reg(5'd12, 32'h11112222);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ReadRegister1 = 5'd12;
    ReadRegister2 = 5'd31;
    #1;
    tests_run++;
    if (ReadData1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_r12: got %08h expected 00000000", ReadData1);
    end
    tests_run++;
    if (ReadData2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset_r31: got %08h expected 00000000", ReadData2);
    end
    write_reg(5'd12, 32'h33334444);
    tests_run++;
    if (ReadData1 !== 32'h33334444) begin
      tests_failed++;
      $display("FAIL midreset_resume: got %08h expected 33334444", ReadData1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    Reset = 1'b1;
    Write = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    tick();
    Reset = 1'b0;
    #1;
    test_reset();
    test_basic_write();
    test_suppressed_move();
    test_reg_zero();
    test_reset_collision();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
